// File: rtl/restoring_div128_pkg.sv
// Shared types and constants for the restoring divider.
// State encoding, default width and the error quotient.
package restoring_div128_pkg;

  localparam int DEF_WIDTH = 64;

  localparam logic [DEF_WIDTH-1:0] Q_ONES = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/restoring_div128_if.sv
// Operand/result valid-ready bundle of the divider.
// master drives operands, slave is the divider.
interface restoring_div128_if #(
  parameter int WIDTH = restoring_div128_pkg::DEF_WIDTH
);

  logic               in_valid;
  logic               in_ready;
  logic [2*WIDTH-1:0] dividend;
  logic [WIDTH-1:0]   divisor;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]   remainder;
  logic               div_by_zero;
  logic               overflow;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder,
    input  div_by_zero, overflow
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder,
    output div_by_zero, overflow
  );

endinterface

// File: rtl/restoring_div128_div_step.sv
// One restoring compare-subtract step.
// Callers keep R < divisor, so the difference fits in WIDTH bits.
module div_step #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH:0]   i_t,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_r,
  output logic             o_qbit
);

  logic [WIDTH-1:0] w_diff;

  assign o_qbit = (i_t >= {1'b0, i_d});
  assign w_diff = i_t[WIDTH-1:0] - i_d;
  assign o_r    = o_qbit ? w_diff : i_t[WIDTH-1:0];

endmodule

// File: rtl/restoring_div128.sv
// Sequential 2W/W restoring divider, one quotient bit per cycle.
// Divide-by-zero and overflow resolve at accept.
module restoring_div128
  import restoring_div128_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  restoring_div128_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [CW-1:0]    r_cnt;
  logic             r_dbz;
  logic             r_ovf;

  logic [WIDTH:0]   w_t;
  logic [WIDTH-1:0] w_r;
  logic             w_qbit;
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;

  assign w_hi = bus.dividend[2*WIDTH-1:WIDTH];
  assign w_lo = bus.dividend[WIDTH-1:0];
  assign w_t  = {r_r, r_q[WIDTH-1]};

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_t    (w_t),
    .i_d    (r_d),
    .o_r    (w_r),
    .o_qbit (w_qbit)
  );

  assign bus.in_ready    = (r_state == IDLE);
  assign bus.out_valid   = (r_state == DONE);
  assign bus.quotient    = r_q;
  assign bus.remainder   = r_r;
  assign bus.div_by_zero = r_dbz;
  assign bus.overflow    = r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_r     <= '0;
      r_q     <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_dbz   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_d   <= bus.divisor;
            r_cnt <= '0;
            if (bus.divisor == '0) begin
              r_dbz   <= 1'b1;
              r_ovf   <= 1'b0;
              r_q     <= '1;
              r_r     <= w_lo;
              r_state <= DONE;
            end else if (w_hi >= bus.divisor) begin
              r_dbz   <= 1'b0;
              r_ovf   <= 1'b1;
              r_q     <= '1;
              r_r     <= w_lo;
              r_state <= DONE;
            end else begin
              r_dbz   <= 1'b0;
              r_ovf   <= 1'b0;
              r_q     <= w_lo;
              r_r     <= w_hi;
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          r_r   <= w_r;
          r_q   <= {r_q[WIDTH-2:0], w_qbit};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
